// File: rtl/fwd_ctrl_pkg.sv
// Types and constants for the dual-lane ID/EX forwarding control stage.
package FwdType;

  localparam int REG_W_DEFAULT = 5;

  typedef enum logic {
    TOP    = 1'b0,
    BOTTOM = 1'b1
  } lane_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/mux3_type_pkg.sv
// Select encoding shared by every three-source operand mux in EX.
// DEFAULT picks the register-file value (with write-through); TOP/BOTTOM pick the MEM-stage ALU lines.
package Mux3Type;

  typedef enum logic [1:0] {
    DEFAULT = 2'd0,
    TOP     = 2'd1,
    BOTTOM  = 2'd2,
    ZERO    = 2'd3
  } mux3_cmd_t;

endpackage

// File: rtl/fwd_ctrl_match.sv
// Per-operand comparator: picks the forwarding source for one ID source register
// against the bundle in EX, and flags a load-use hazard.
module fwd_match
  import FwdType::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0]      src,
  input  logic [1:0]            ex_valid,
  input  logic [1:0]            ex_we,
  input  logic [1:0]            ex_load,
  input  logic [1:0][REG_W-1:0] ex_rd,
  output Mux3Type::mux3_cmd_t   cmd,
  output logic                  hazard
);

  logic hit_top;
  logic hit_bot;

  assign hit_top = ex_valid[TOP]    && ex_we[TOP]    && (ex_rd[TOP]    == src);
  assign hit_bot = ex_valid[BOTTOM] && ex_we[BOTTOM] && (ex_rd[BOTTOM] == src);

  // BOTTOM is checked first: it is younger in program order and shadows TOP.
  always_comb begin
    cmd    = Mux3Type::DEFAULT;
    hazard = 1'b0;
    if (src == '0) begin
      cmd = Mux3Type::ZERO;
    end else if (hit_bot) begin
      if (ex_load[BOTTOM]) hazard = 1'b1;
      else                 cmd    = Mux3Type::BOTTOM;
    end else if (hit_top) begin
      if (ex_load[TOP]) hazard = 1'b1;
      else              cmd    = Mux3Type::TOP;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// ID/EX forwarding control for the TOP/BOTTOM lanes: registers operand mux selects for EX,
// raises a one-cycle load-use stall with a bubble, and counts stall cycles (saturating).
module fwd_ctrl
  import FwdType::*;
#(
  parameter int REG_W = REG_W_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv,
  input  logic                       flush,
  input  logic [1:0]                 id_valid,
  input  logic [1:0][REG_W-1:0]      id_rs1,
  input  logic [1:0][REG_W-1:0]      id_rs2,
  input  logic [1:0][REG_W-1:0]      id_rd,
  input  logic [1:0]                 id_we,
  input  logic [1:0]                 id_load,
  output Mux3Type::mux3_cmd_t [1:0]  ex_cmd_rs1,
  output Mux3Type::mux3_cmd_t [1:0]  ex_cmd_rs2,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam Mux3Type::mux3_cmd_t [1:0] CMD_IDLE = '{Mux3Type::DEFAULT, Mux3Type::DEFAULT};

  logic [1:0]                ex_valid_reg;
  logic [1:0]                ex_we_reg;
  logic [1:0]                ex_load_reg;
  logic [1:0][REG_W-1:0]     ex_rd_reg;
  fwd_state_e                state_reg;
  fwd_state_e                state_next;
  Mux3Type::mux3_cmd_t [1:0] cmd_rs1_reg;
  Mux3Type::mux3_cmd_t [1:0] cmd_rs2_reg;
  Mux3Type::mux3_cmd_t [1:0] cmd_rs1_next;
  Mux3Type::mux3_cmd_t [1:0] cmd_rs2_next;
  logic [1:0]                haz_rs1;
  logic [1:0]                haz_rs2;
  logic [CNT_W-1:0]          stall_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      Mux3Type::mux3_cmd_t m_rs1;
      Mux3Type::mux3_cmd_t m_rs2;
      logic                h_rs1;
      logic                h_rs2;

      fwd_match #(.REG_W(REG_W)) u_match_rs1 (
        .src      (id_rs1[gi]),
        .ex_valid (ex_valid_reg),
        .ex_we    (ex_we_reg),
        .ex_load  (ex_load_reg),
        .ex_rd    (ex_rd_reg),
        .cmd      (m_rs1),
        .hazard   (h_rs1)
      );

      fwd_match #(.REG_W(REG_W)) u_match_rs2 (
        .src      (id_rs2[gi]),
        .ex_valid (ex_valid_reg),
        .ex_we    (ex_we_reg),
        .ex_load  (ex_load_reg),
        .ex_rd    (ex_rd_reg),
        .cmd      (m_rs2),
        .hazard   (h_rs2)
      );

      // Invalid lanes neither forward nor stall.
      assign cmd_rs1_next[gi] = id_valid[gi] ? m_rs1 : Mux3Type::DEFAULT;
      assign cmd_rs2_next[gi] = id_valid[gi] ? m_rs2 : Mux3Type::DEFAULT;
      assign haz_rs1[gi]      = id_valid[gi] & h_rs1;
      assign haz_rs2[gi]      = id_valid[gi] & h_rs2;
    end
  endgenerate

  // EX always holds a bubble in STALL, so the state term only makes that explicit.
  assign stall = adv && !flush && (state_reg == RUN) && (|{haz_rs1, haz_rs2});

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = RUN;
    end else if (adv) begin
      case (state_reg)
        RUN:     if (stall) state_next = STALL;
        STALL:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      ex_valid_reg <= '0;
      ex_we_reg    <= '0;
      ex_load_reg  <= '0;
      ex_rd_reg    <= '0;
      cmd_rs1_reg  <= CMD_IDLE;
      cmd_rs2_reg  <= CMD_IDLE;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        ex_valid_reg <= '0;
        cmd_rs1_reg  <= CMD_IDLE;
        cmd_rs2_reg  <= CMD_IDLE;
      end else if (adv) begin
        if (stall) begin
          ex_valid_reg <= '0;
          cmd_rs1_reg  <= CMD_IDLE;
          cmd_rs2_reg  <= CMD_IDLE;
        end else begin
          ex_valid_reg <= id_valid;
          ex_we_reg    <= id_we;
          ex_load_reg  <= id_load;
          ex_rd_reg    <= id_rd;
          cmd_rs1_reg  <= cmd_rs1_next;
          cmd_rs2_reg  <= cmd_rs2_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign ex_cmd_rs1 = cmd_rs1_reg;
  assign ex_cmd_rs2 = cmd_rs2_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule
